mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, load/store port and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one pipelined memory port with an in-order response FIFO.
// Define ARB_ROUND_ROBIN_EN to alternate priority between sources; default is fixed data-over-inst priority.
module mem_port_arbiter #(
  parameter int unsigned OUTST_DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUTST_DEPTH + 1);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK_INST,
    ST_LOCK_DATA
  } lock_state_t;

  lock_state_t          state;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [OUTST_DEPTH-1:0] src_fifo;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_data;
`endif

  logic both_prio;
  logic sel_src;
  logic full;
  logic mem_req_c;
  logic handshake;
  logic pop;
  logic head_src;

  // Source selection, issue gating and response routing
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    both_prio = prio_data;
`else
    both_prio = SRC_DATA;
`endif
    full = (count == CNT_W'(OUTST_DEPTH));
    if (state == ST_LOCK_INST) begin
      sel_src = SRC_INST;
    end else if (state == ST_LOCK_DATA) begin
      sel_src = SRC_DATA;
    end else if (bus.data_req && bus.inst_req) begin
      sel_src = both_prio;
    end else begin
      sel_src = bus.data_req ? SRC_DATA : SRC_INST;
    end
    mem_req_c = resetn && !full &&
                ((state != ST_IDLE) || bus.inst_req || bus.data_req);
    handshake = mem_req_c && bus.mem_addr_ok;
    head_src  = src_fifo[rptr];
    pop       = resetn && bus.mem_data_ok && (count != '0);
  end

  assign bus.mem_req      = mem_req_c;
  assign bus.mem_wr       = (sel_src == SRC_DATA) ? bus.data_wr    : 1'b0;
  assign bus.mem_wstrb    = (sel_src == SRC_DATA) ? bus.data_wstrb : 4'b0000;
  assign bus.mem_addr     = (sel_src == SRC_DATA) ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata    = (sel_src == SRC_DATA) ? bus.data_wdata : 32'h0;

  assign bus.inst_addr_ok = handshake && (sel_src == SRC_INST);
  assign bus.data_addr_ok = handshake && (sel_src == SRC_DATA);
  assign bus.inst_data_ok = pop && (head_src == SRC_INST);
  assign bus.data_data_ok = pop && (head_src == SRC_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  // Lock FSM, source-ID FIFO and priority pointer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_data <= SRC_DATA;
`endif
    end else begin
      if (mem_req_c && !bus.mem_addr_ok) begin
        state <= (sel_src == SRC_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
      end else if (handshake) begin
        state <= ST_IDLE;
      end

      if (handshake) begin
        src_fifo[wptr] <= sel_src;
        wptr           <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (handshake && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!handshake && pop) begin
        count <= count - CNT_W'(1);
      end

`ifdef ARB_ROUND_ROBIN_EN
      // The source not granted at this handshake wins the next tie.
      if (handshake) begin
        prio_data <= (sel_src == SRC_INST);
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (OUTST_DEPTH = 2).
// The round-robin scenario runs only when ARB_ROUND_ROBIN_EN is defined.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.OUTST_DEPTH(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_wstrb  = 4'h0;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.inst_req = 1'b1; bus.data_req = 1'b1;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
    cyc(); cyc(); #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %0b want 0", bus.mem_req); end
    n_cmp++; if (bus.inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_inst_addr_ok got %0b want 0", bus.inst_addr_ok); end
    n_cmp++; if (bus.data_addr_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_addr_ok got %0b want 0", bus.data_addr_ok); end
    n_cmp++; if (bus.inst_data_ok !== 1'b0) begin n_err++; $display("FAIL rst_inst_data_ok got %0b want 0", bus.inst_data_ok); end
    n_cmp++; if (bus.data_data_ok !== 1'b0) begin n_err++; $display("FAIL rst_data_data_ok got %0b want 0", bus.data_data_ok); end
    idle_inputs();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_priority();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0100;
    bus.data_req = 1'b1; bus.data_addr = 32'h8000_0000;
    bus.mem_addr_ok = 1'b1; #1;
    n_cmp++; if (bus.data_addr_ok !== 1'b1) begin n_err++; $display("FAIL prio_data_addr_ok got %0b want 1", bus.data_addr_ok); end
    n_cmp++; if (bus.inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL prio_inst_addr_ok got %0b want 0", bus.inst_addr_ok); end
    n_cmp++; if (bus.mem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL prio_mem_addr got %h want 80000000", bus.mem_addr); end
    cyc();
    bus.data_req = 1'b0; #1;
    n_cmp++; if (bus.inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL prio_inst_next got %0b want 1", bus.inst_addr_ok); end
    n_cmp++; if (bus.mem_addr !== 32'h1c00_0100) begin n_err++; $display("FAIL prio_inst_addr got %h want 1c000100", bus.mem_addr); end
    n_cmp++; if ({bus.mem_wr, bus.mem_wstrb} !== 5'b0) begin n_err++; $display("FAIL prio_inst_wr got %b want 00000", {bus.mem_wr, bus.mem_wstrb}); end
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'haaaa_5555; #1;
    n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b10) begin n_err++; $display("FAIL prio_resp1 got %b want 10", {bus.data_data_ok, bus.inst_data_ok}); end
    n_cmp++; if (bus.data_rdata !== 32'haaaa_5555) begin n_err++; $display("FAIL prio_rdata got %h want aaaa5555", bus.data_rdata); end
    cyc();
    bus.mem_rdata = 32'h0000_0001; #1;
    n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b01) begin n_err++; $display("FAIL prio_resp2 got %b want 01", {bus.data_data_ok, bus.inst_data_ok}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_lock();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0000; #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h1c00_0000) begin n_err++; $display("FAIL lock_c0 got req=%0b addr=%h want 1/1c000000", bus.mem_req, bus.mem_addr); end
    cyc();
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'hf;
    bus.data_addr = 32'h8000_0010; bus.data_wdata = 32'hdead_beef; #1;
    n_cmp++; if (bus.mem_addr !== 32'h1c00_0000) begin n_err++; $display("FAIL lock_c1_addr got %h want 1c000000", bus.mem_addr); end
    n_cmp++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL lock_c1_wr got %0b want 0", bus.mem_wr); end
    cyc();
    #1;
    n_cmp++; if (bus.mem_addr !== 32'h1c00_0000) begin n_err++; $display("FAIL lock_c2_addr got %h want 1c000000", bus.mem_addr); end
    cyc();
    bus.mem_addr_ok = 1'b1; #1;
    n_cmp++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) begin n_err++; $display("FAIL lock_hs got %b want 10", {bus.inst_addr_ok, bus.data_addr_ok}); end
    cyc();
    bus.inst_req = 1'b0; #1;
    n_cmp++; if (bus.data_addr_ok !== 1'b1 || bus.mem_addr !== 32'h8000_0010) begin n_err++; $display("FAIL lock_data got ok=%0b addr=%h want 1/80000010", bus.data_addr_ok, bus.mem_addr); end
    n_cmp++; if ({bus.mem_wr, bus.mem_wstrb, bus.mem_wdata} !== {1'b1, 4'hf, 32'hdead_beef}) begin n_err++; $display("FAIL lock_store got %b %h %h want 1 f deadbeef", bus.mem_wr, bus.mem_wstrb, bus.mem_wdata); end
    cyc();
    bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) begin n_err++; $display("FAIL lock_resp1 got %b want 10", {bus.inst_data_ok, bus.data_data_ok}); end
    cyc();
    #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b01) begin n_err++; $display("FAIL lock_resp2 got %b want 01", {bus.inst_data_ok, bus.data_data_ok}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_full();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0200; bus.mem_addr_ok = 1'b1; #1;
    n_cmp++; if (bus.inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_hs1 got %0b want 1", bus.inst_addr_ok); end
    cyc();
    bus.inst_addr = 32'h1c00_0204; #1;
    n_cmp++; if (bus.inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_hs2 got %0b want 1", bus.inst_addr_ok); end
    cyc();
    bus.inst_addr = 32'h1c00_0208; bus.mem_data_ok = 1'b1; #1;
    n_cmp++; if (bus.mem_req !== 1'b0 || bus.inst_addr_ok !== 1'b0) begin n_err++; $display("FAIL full_block got req=%0b ok=%0b want 0/0", bus.mem_req, bus.inst_addr_ok); end
    n_cmp++; if (bus.inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_pop got %0b want 1", bus.inst_data_ok); end
    cyc();
    bus.mem_data_ok = 1'b0; #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_resume got req=%0b ok=%0b want 1/1", bus.mem_req, bus.inst_addr_ok); end
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; #1;
    n_cmp++; if (bus.inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_drain1 got %0b want 1", bus.inst_data_ok); end
    cyc();
    #1;
    n_cmp++; if (bus.inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_drain2 got %0b want 1", bus.inst_data_ok); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_order();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0300; bus.mem_addr_ok = 1'b1;
    cyc();
    bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'h3;
    bus.data_addr = 32'h8000_0020; #1;
    n_cmp++; if (bus.data_addr_ok !== 1'b1) begin n_err++; $display("FAIL order_store_hs got %0b want 1", bus.data_addr_ok); end
    cyc();
    bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1234_5678; #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) begin n_err++; $display("FAIL order_first got %b want 10", {bus.inst_data_ok, bus.data_data_ok}); end
    n_cmp++; if (bus.inst_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL order_rdata got %h want 12345678", bus.inst_rdata); end
    cyc();
    bus.mem_rdata = 32'h0; #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b01) begin n_err++; $display("FAIL order_second got %b want 01", {bus.inst_data_ok, bus.data_data_ok}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bus.data_req = 1'b1; bus.data_addr = 32'h8000_0040; bus.mem_addr_ok = 1'b1;
    cyc();
    bus.data_req = 1'b0; bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0400; bus.mem_data_ok = 1'b1; #1;
    n_cmp++; if ({bus.inst_addr_ok, bus.data_data_ok, bus.inst_data_ok} !== 3'b110) begin n_err++; $display("FAIL b2b_c1 got %b want 110", {bus.inst_addr_ok, bus.data_data_ok, bus.inst_data_ok}); end
    cyc();
    bus.inst_req = 1'b0; bus.data_req = 1'b1; #1;
    n_cmp++; if ({bus.data_addr_ok, bus.data_data_ok, bus.inst_data_ok} !== 3'b101) begin n_err++; $display("FAIL b2b_c2 got %b want 101", {bus.data_addr_ok, bus.data_data_ok, bus.inst_data_ok}); end
    cyc();
    bus.data_req = 1'b0; bus.inst_req = 1'b1; #1;
    n_cmp++; if ({bus.inst_addr_ok, bus.data_data_ok, bus.inst_data_ok} !== 3'b110) begin n_err++; $display("FAIL b2b_c3 got %b want 110", {bus.inst_addr_ok, bus.data_data_ok, bus.inst_data_ok}); end
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; #1;
    n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b01) begin n_err++; $display("FAIL b2b_c4 got %b want 01", {bus.data_data_ok, bus.inst_data_ok}); end
    cyc();
    #1;
    n_cmp++; if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b00) begin n_err++; $display("FAIL b2b_empty got %b want 00", {bus.data_data_ok, bus.inst_data_ok}); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0500; bus.mem_addr_ok = 1'b1;
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    resetn = 1'b0;
    cyc();
    resetn = 1'b1; bus.mem_data_ok = 1'b1; #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin n_err++; $display("FAIL rstmid_stray got %b want 00", {bus.inst_data_ok, bus.data_data_ok}); end
    cyc();
    #1;
    n_cmp++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin n_err++; $display("FAIL rstmid_stray2 got %b want 00", {bus.inst_data_ok, bus.data_data_ok}); end
    cyc();
    bus.mem_data_ok = 1'b0; bus.inst_req = 1'b1; bus.mem_addr_ok = 1'b1; #1;
    n_cmp++; if (bus.inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL rstmid_new_hs got %0b want 1", bus.inst_addr_ok); end
    cyc();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; #1;
    n_cmp++; if (bus.inst_data_ok !== 1'b1) begin n_err++; $display("FAIL rstmid_new_resp got %0b want 1", bus.inst_data_ok); end
    cyc();
    #1;
    n_cmp++; if (bus.inst_data_ok !== 1'b0) begin n_err++; $display("FAIL rstmid_after got %0b want 0", bus.inst_data_ok); end
    cyc();
    idle_inputs();
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [3:0] grants;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0600;
    bus.data_req = 1'b1; bus.data_addr = 32'h8000_0600;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      grants[3-i] = bus.data_addr_ok;
      n_cmp++; if ((bus.data_addr_ok ^ bus.inst_addr_ok) !== 1'b1) begin n_err++; $display("FAIL rr_onehot_%0d got d=%0b i=%0b", i, bus.data_addr_ok, bus.inst_addr_ok); end
      cyc();
    end
    n_cmp++; if (grants !== 4'b1010) begin n_err++; $display("FAIL rr_sequence got %b want 1010", grants); end
    bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0;
    cyc(); cyc();
    idle_inputs();
  endtask
`endif

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_priority();
    test_lock();
    test_full();
    test_order();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
